// File: rtl/get_pq.sv
// Elliptic-curve point adder R = P + Q over GF(prime), with doubling and infinity handling.
// Uses a binary extended-Euclid inverse and a bit-serial modular multiplier, so no wide product is ever built.
module get_pq #(
    parameter int integer_size = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [integer_size-1:0] prime,
    input  logic [integer_size-1:0] A,
    input  logic [integer_size-1:0] B,
    input  logic [integer_size-1:0] Px,
    input  logic [integer_size-1:0] Py,
    input  logic [integer_size-1:0] Qx,
    input  logic [integer_size-1:0] Qy,
    input  logic                    infiniteP,
    input  logic                    infiniteQ,
    output logic [integer_size-1:0] PQx,
    output logic [integer_size-1:0] PQy,
    output logic                    infinitePQ,
    output logic                    done
);
    localparam int W  = integer_size;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, CLASSIFY, INV, MUL, DONE} state_t;
    state_t state, state_n;

    logic [W-1:0]  p, a_r, b_r, px, py, qx, qy;
    logic          infp, infq, dbl_r;
    logic [W-1:0]  num, inv, lam, u, v, x1, x2;
    logic [W-1:0]  ma, mb, macc;
    logic [CW-1:0] mcnt;
    logic [1:0]    phase;

    function automatic logic [W-1:0] madd(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] msub(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        return (a >= b) ? a - b : a + (m - b);
    endfunction

    // x/2 mod m: odd values get m added first so the shift stays exact
    function automatic logic [W-1:0] mhalf(input logic [W-1:0] x, input logic [W-1:0] m);
        logic [W:0] s;
        s = x[0] ? {1'b0, x} + {1'b0, m} : {1'b0, x};
        return s[W:1];
    endfunction

    logic         same_x, inv_pt, trivial, dbl, inv_hit, mul_last;
    logic [W-1:0] den_v, inv_v, t1, mul_next, n3, rx_v, ry_v;

    assign same_x   = (px == qx);
    assign inv_pt   = same_x && ((py != qy) || (py == '0));
    assign trivial  = infp || infq || inv_pt;
    assign dbl      = same_x && !inv_pt;
    assign den_v    = dbl ? madd(py, py, p) : msub(qx, px, p);
    assign inv_hit  = (u == W'(1)) || (v == W'(1));
    assign inv_v    = (u == W'(1)) ? x1 : x2;
    assign mul_last = (mcnt == CW'(W - 1));

    // MSB-first shift-add: acc = 2*acc (+ ma), each step reduced back below prime
    assign t1       = madd(macc, macc, p);
    assign mul_next = mb[W-1] ? madd(t1, ma, p) : t1;
    assign n3       = madd(madd(madd(mul_next, mul_next, p), mul_next, p), a_r, p);
    assign rx_v     = msub(msub(mul_next, px, p), qx, p);
    assign ry_v     = msub(mul_next, py, p);

    logic unused_b;
    assign unused_b = ^b_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (go) state_n = LOAD;
            LOAD:     state_n = CLASSIFY;
            CLASSIFY: state_n = trivial ? DONE : INV;
            INV:      if (inv_hit) state_n = MUL;
            MUL:      if (mul_last && phase == 2'd3) state_n = DONE;
            DONE:     if (!go) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= '0; a_r <= '0; b_r <= '0;
            px <= '0; py <= '0; qx <= '0; qy <= '0;
            infp <= 1'b0; infq <= 1'b0; dbl_r <= 1'b0;
            num <= '0; inv <= '0; lam <= '0;
            u <= '0; v <= '0; x1 <= '0; x2 <= '0;
            ma <= '0; mb <= '0; macc <= '0; mcnt <= '0; phase <= '0;
            PQx <= '0; PQy <= '0; infinitePQ <= 1'b0; done <= 1'b0;
        end else begin
            case (state)
                IDLE: done <= 1'b0;
                LOAD: begin
                    p    <= prime;
                    a_r  <= A % prime;
                    b_r  <= B;
                    px   <= Px % prime;
                    py   <= Py % prime;
                    qx   <= Qx % prime;
                    qy   <= Qy % prime;
                    infp <= infiniteP;
                    infq <= infiniteQ;
                end
                CLASSIFY: begin
                    if (trivial) begin
                        done <= 1'b1;
                        if ((infp && infq) || (!infp && !infq)) begin
                            PQx <= '0; PQy <= '0; infinitePQ <= 1'b1;
                        end else if (infp) begin
                            PQx <= qx; PQy <= qy; infinitePQ <= 1'b0;
                        end else begin
                            PQx <= px; PQy <= py; infinitePQ <= 1'b0;
                        end
                    end else begin
                        dbl_r <= dbl;
                        num   <= msub(qy, py, p);
                        u     <= den_v;
                        v     <= p;
                        x1    <= W'(1);
                        x2    <= '0;
                    end
                end
                INV: begin
                    if (inv_hit) begin
                        inv  <= inv_v;
                        macc <= '0;
                        mcnt <= '0;
                        if (dbl_r) begin
                            ma <= px; mb <= px; phase <= 2'd0;
                        end else begin
                            ma <= num; mb <= inv_v; phase <= 2'd1;
                        end
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= mhalf(x1, p);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= mhalf(x2, p);
                    end else if (u >= v) begin
                        u  <= (u - v) >> 1;
                        x1 <= mhalf(msub(x1, x2, p), p);
                    end else begin
                        v  <= (v - u) >> 1;
                        x2 <= mhalf(msub(x2, x1, p), p);
                    end
                end
                MUL: begin
                    if (!mul_last) begin
                        macc <= mul_next;
                        mb   <= {mb[W-2:0], 1'b0};
                        mcnt <= mcnt + CW'(1);
                    end else begin
                        macc  <= '0;
                        mcnt  <= '0;
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0: begin
                                num <= n3; ma <= n3; mb <= inv;
                            end
                            2'd1: begin
                                lam <= mul_next; ma <= mul_next; mb <= mul_next;
                            end
                            2'd2: begin
                                PQx <= rx_v; ma <= lam; mb <= msub(px, rx_v, p);
                            end
                            default: begin
                                PQy <= ry_v; infinitePQ <= 1'b0; done <= 1'b1;
                            end
                        endcase
                    end
                end
                DONE: if (!go) done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_get_pq.sv
// Directed bench for get_pq on y^2 = x^3 + 2x + 2 mod 17; expected points pushed to a scoreboard,
// popped and compared by a monitor on each rising edge of done.
module tb_get_pq;
    localparam int W = 64;
    localparam int BOUND = 6 * W + 20;

    logic         clk = 1'b0;
    logic         rst, go;
    logic [W-1:0] prime, A, B, Px, Py, Qx, Qy;
    logic         infiniteP, infiniteQ;
    logic [W-1:0] PQx, PQy;
    logic         infinitePQ, done;

    get_pq #(.integer_size(W)) dut (
        .clk(clk), .rst(rst), .go(go), .prime(prime), .A(A), .B(B),
        .Px(Px), .Py(Py), .Qx(Qx), .Qy(Qy),
        .infiniteP(infiniteP), .infiniteQ(infiniteQ),
        .PQx(PQx), .PQy(PQy), .infinitePQ(infinitePQ), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         inf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic done_q = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && done && !done_q) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no result pending");
            end else begin
                e = sb.pop_front();
                check("PQx", PQx, e.x);
                check("PQy", PQy, e.y);
                check("infinitePQ", W'(infinitePQ), W'(e.inf));
            end
        end
        done_q = rst ? done : 1'b0;
    end

    task automatic expect_pt(input logic [W-1:0] ex, input logic [W-1:0] ey, input logic einf);
        exp_t e;
        e.x = ex; e.y = ey; e.inf = einf;
        sb.push_back(e);
    endtask

    task automatic set_pts(input logic [W-1:0] px, input logic [W-1:0] py,
                           input logic [W-1:0] qx, input logic [W-1:0] qy,
                           input logic ip, input logic iq);
        Px = px; Py = py; Qx = qx; Qy = qy; infiniteP = ip; infiniteQ = iq;
    endtask

    task automatic wait_done();
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (done) return;
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: got no done within %0d cycles, expected done", BOUND);
    endtask

    // Hold go while done is high, then drop it and confirm done falls one cycle later with outputs kept
    task automatic finish_op(input logic [W-1:0] ex, input logic [W-1:0] ey, input logic einf,
                             input int hold);
        wait_done();
        repeat (hold) begin
            @(negedge clk);
            check("done_held", W'(done), W'(1));
        end
        @(posedge clk); #1 go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("done_drop", W'(done), W'(0));
        check("hold_x", PQx, ex);
        check("hold_y", PQy, ey);
        check("hold_inf", W'(infinitePQ), W'(einf));
    endtask

    task automatic run_op(input logic [W-1:0] px, input logic [W-1:0] py,
                          input logic [W-1:0] qx, input logic [W-1:0] qy,
                          input logic ip, input logic iq,
                          input logic [W-1:0] ex, input logic [W-1:0] ey, input logic einf,
                          input int hold);
        expect_pt(ex, ey, einf);
        @(posedge clk); #1;
        set_pts(px, py, qx, qy, ip, iq);
        go = 1'b1;
        finish_op(ex, ey, einf, hold);
    endtask

    initial begin
        rst = 1'b0; go = 1'b0;
        prime = 64'd17; A = 64'd2; B = 64'd2;
        set_pts('0, '0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_done", W'(done), W'(0));
        check("rst_x", PQx, '0);
        check("rst_y", PQy, '0);
        check("rst_inf", W'(infinitePQ), W'(0));
        rst = 1'b1;

        run_op(5, 1, 6, 3, 1'b0, 1'b0, 10, 6, 1'b0, 3);
        run_op(5, 1, 5, 1, 1'b0, 1'b0, 6, 3, 1'b0, 1);
        run_op(10, 6, 5, 1, 1'b0, 1'b0, 3, 1, 1'b0, 1);
        run_op(5, 1, 5, 16, 1'b0, 1'b0, 0, 0, 1'b1, 1);
        run_op(5, 1, 6, 3, 1'b1, 1'b0, 6, 3, 1'b0, 1);
        run_op(9, 16, 7, 7, 1'b0, 1'b1, 9, 16, 1'b0, 1);
        run_op(5, 1, 6, 3, 1'b1, 1'b1, 0, 0, 1'b1, 1);
        run_op(4, 0, 4, 0, 1'b0, 1'b0, 0, 0, 1'b1, 1);
        run_op(22, 18, 6, 3, 1'b0, 1'b0, 10, 6, 1'b0, 1);
        run_op(10, 6, 10, 6, 1'b0, 1'b0, 16, 13, 1'b0, 1);

        // go dropped right after the start: completes and pulses done for one cycle
        expect_pt(5, 1, 1'b0);
        @(posedge clk); #1;
        set_pts(5, 16, 6, 3, 1'b0, 1'b0);
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        wait_done();
        @(negedge clk);
        check("pulse_done", W'(done), W'(0));
        check("pulse_x", PQx, 64'd5);

        // asynchronous reset in the middle of a computation
        @(posedge clk); #1;
        set_pts(5, 1, 6, 3, 1'b0, 1'b0);
        go = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_done", W'(done), W'(0));
        check("abort_x", PQx, '0);
        check("abort_y", PQy, '0);
        check("abort_inf", W'(infinitePQ), W'(0));
        expect_pt(10, 6, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        finish_op(10, 6, 1'b0, 1);

        // back-to-back requests with go dropped in between
        run_op(5, 1, 6, 3, 1'b0, 1'b0, 10, 6, 1'b0, 1);
        run_op(10, 6, 10, 6, 1'b0, 1'b0, 16, 13, 1'b0, 1);

        repeat (2) @(negedge clk);
        check("sb_drained", W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/get_pq.md
Name: get_pq

Overview:
- Sequential elliptic-curve point adder over a prime field: computes R = P + Q on y^2 = x^3 + A*x + B (mod prime), including doubling and point-at-infinity cases.
- Sits after the two scalar-multiply ladders in the ECDSA verify datapath and combines u1*G and u2*Q into the final point.
- Its x coordinate feeds the r-check.

Parameters:
- integer_size, 64, bit width of the field prime, curve coefficients and all coordinates.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- go  input  1  level start request; held high by the master until done is seen, then dropped.
- prime  input  integer_size  field modulus, an odd prime >= 3.
- A  input  integer_size  curve coefficient a.
- B  input  integer_size  curve coefficient b; latched, not used in the arithmetic.
- Px, Py  input  integer_size  point P coordinates.
- Qx, Qy  input  integer_size  point Q coordinates.
- infiniteP  input  1  P is the point at infinity; Px/Py are ignored.
- infiniteQ  input  1  Q is the point at infinity; Qx/Qy are ignored.
- PQx, PQy  output  integer_size  result coordinates, registered.
- infinitePQ  output  1  result is the point at infinity, registered.
- done  output  1  result valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; done=0; PQx=PQy=0; infinitePQ=0; all internal registers cleared. A reset asserted mid-computation aborts it immediately with no partial result visible.
- States: IDLE, LOAD, CLASSIFY, INV (modular inverse), MUL (lambda and result products), DONE.
- IDLE: done=0; outputs hold the last result. When go=1, go to LOAD.
- LOAD (1 cycle): latch all inputs. Reduce every coordinate and A mod prime.
- CLASSIFY (1 cycle):
  - infiniteP and infiniteQ both set -> infinity.
  - Only infiniteP set -> R=Q.
  - Only infiniteQ set -> R=P.
  - Px==Qx and (Py!=Qy or Py==0) -> infinity.
  - Px==Qx and Py==Qy, Py!=0 -> doubling: num = 3*Px^2 + A, den = 2*Py.
  - Otherwise -> add: num = Qy-Py, den = Qx-Px.
  - Trivial cases (infinity, R=P, R=Q) go directly to DONE. Infinity reports PQx=PQy=0, infinitePQ=1. R=P or R=Q reports the reduced coordinates with infinitePQ=0.
- INV: den^-1 mod prime by iterative extended Euclid, one step per cycle; at most 2*integer_size+2 cycles.
- MUL: products use a sequential shift-add modular multiplier, one bit per cycle, with intermediates kept below 2*prime so no wide product is built.
  - lambda = num * den^-1
  - Rx = lambda^2 - Px - Qx
  - Ry = lambda*(Px - Rx) - Py
  - All results are in [0, prime).
  - Subtraction is done as a-b, plus prime when a<b.
- DONE: load PQx, PQy and infinitePQ, and assert done=1. Hold done and the outputs while go=1. When go=0, return to IDLE, where done drops the next cycle and the outputs keep their values.
- Inputs are sampled only in LOAD. Changes to inputs while busy have no effect.
- go dropping before DONE does not abort the computation; the block completes, pulses done for one cycle, then returns to IDLE.
- Latency from go to done is data-dependent but bounded by 6*integer_size+8 cycles.
- Simultaneous infiniteP and infiniteQ takes the infinity case, as listed in CLASSIFY.

Test Plan:
- Curve p=17, A=2, B=2. P=(5,1), Q=(6,3), go held -> done=1, PQ=(10,6), infinitePQ=0; done stays high until go drops, then 0 one cycle later.
- Doubling: P=Q=(5,1) -> PQ=(6,3), infinitePQ=0. Also P=(10,6), Q=(5,1) -> PQ=(3,1).
- Inverse points: P=(5,1), Q=(5,16) -> infinitePQ=1, PQ=(0,0).
- Infinity inputs:
  - infiniteP=1, Q=(6,3) -> PQ=(6,3).
  - infiniteQ=1, P=(9,16) -> PQ=(9,16).
  - Both flags set -> infinitePQ=1.
- Reset mid-op: start P=(5,1), Q=(6,3); pull rst low 3 cycles later -> done=0 and PQ=(0,0) immediately. After release with go=1, a fresh run yields (10,6).
- Back-to-back: two consecutive requests with go dropped between them -> the second result replaces the first, and done deasserts in between.
